// File: rtl/clkdiv_pll_gen.sv
// rtl/clkdiv_pll_gen.sv - PLL-style clock-enable generator with lock sequencing and runtime divisors
// Optional per-channel start phase: define CLKDIV_PHASE_EN
module clkdiv_pll_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_DIV     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LC_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] clken,
  output logic              lock
);

  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_X  = (DIV_W + 1)'(1);
  localparam logic [LC_W-1:0]  LC_END = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic {LOCKING, LOCKED} state_t;

  state_t           state;
  logic [LC_W-1:0]  lock_cnt;
  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] phase_q [NUM_CH];
`endif

  logic [DIV_W-1:0]  d_eff  [NUM_CH];
  logic [DIV_W-1:0]  d_last [NUM_CH];
  logic [DIV_W-1:0]  start  [NUM_CH];
  logic [DIV_W-1:0]  cnt_nx [NUM_CH];
  logic [DIV_W:0]    half   [NUM_CH];
  logic [NUM_CH-1:0] out_start, en_start, out_nx, en_nx;
  logic [31:0]       ch_ext;
  logic              ch_ok;

  assign ch_ext = 32'(cfg_ch);
  assign ch_ok  = ch_ext < NUM_CH;

  // Outputs are registered from the counter value the channel will hold next cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_eff[i]  = (div_q[i] == '0) ? ONE : div_q[i];
      d_last[i] = d_eff[i] - ONE;
      half[i]   = ({1'b0, d_eff[i]} + ONE_X) >> 1;
`ifdef CLKDIV_PHASE_EN
      start[i]  = (phase_q[i] < d_eff[i]) ? phase_q[i] : '0;
`else
      start[i]  = '0;
`endif
      cnt_nx[i]    = (cnt_q[i] == d_last[i]) ? '0 : cnt_q[i] + ONE;
      out_start[i] = {1'b0, start[i]} < half[i];
      en_start[i]  = start[i] == d_last[i];
      out_nx[i]    = {1'b0, cnt_nx[i]} < half[i];
      en_nx[i]     = cnt_nx[i] == d_last[i];
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= LOCKING;
      lock_cnt  <= '0;
      lock      <= 1'b0;
      cfg_ready <= 1'b0;
      clkout    <= '0;
      clken     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DEF_DIV);
        cnt_q[i] <= '0;
`ifdef CLKDIV_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      case (state)
        LOCKING: begin
          for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= start[i];
          lock_cnt <= lock_cnt + LC_W'(1);
          if (lock_cnt == LC_END) begin
            state     <= LOCKED;
            lock      <= 1'b1;
            cfg_ready <= 1'b1;
            clkout    <= out_start;
            clken     <= en_start;
          end
        end
        LOCKED: begin
          if (cfg_valid && ch_ok) begin
            div_q[cfg_ch] <= cfg_div;
`ifdef CLKDIV_PHASE_EN
            phase_q[cfg_ch] <= cfg_phase;
`endif
            // Counters are reloaded to their start values while relocking.
            state     <= LOCKING;
            lock_cnt  <= '0;
            lock      <= 1'b0;
            cfg_ready <= 1'b0;
            clkout    <= '0;
            clken     <= '0;
          end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nx[i];
            clkout <= out_nx;
            clken  <= en_nx;
          end
        end
        default: state <= LOCKING;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_pll_gen.sv
// tb/tb_clkdiv_pll_gen.sv - scoreboard bench for clkdiv_pll_gen against a cycle-count reference model
module tb_clkdiv_pll_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 64;
  localparam int DEF_DIV     = 2;

  logic              clkin = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0]  cfg_phase = '0;
`endif
  logic [NUM_CH-1:0] clkout, clken;
  logic              lock;

  clkdiv_pll_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DEF_DIV(DEF_DIV)
  ) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .clkout(clkout), .clken(clken), .lock(lock)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int                cyc;
    logic              lk;
    logic              rdy;
    logic [NUM_CH-1:0] co;
    logic [NUM_CH-1:0] ce;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: cycles elapsed since the last reset release or accepted reconfiguration.
  int   m_t = 0;
  bit   m_ok = 0;
  int   m_div [NUM_CH];
  int   m_ph  [NUM_CH];

  task automatic step(input logic rst, input logic v, input int ch, input int dv, input int ph);
    exp_t e;
    int   d, s, p;
    @(posedge clkin);
    #1;
    cyc++;
    reset     = rst;
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = DIV_W'(dv);
`ifdef CLKDIV_PHASE_EN
    cfg_phase = DIV_W'(ph);
`endif
    if (m_ok) begin
      e.cyc = cyc;
      e.lk  = (m_t >= LOCK_CYCLES);
      e.rdy = e.lk;
      e.co  = '0;
      e.ce  = '0;
      if (e.lk) begin
        for (int i = 0; i < NUM_CH; i++) begin
          d = (m_div[i] == 0) ? 1 : m_div[i];
          s = (m_ph[i] < d) ? m_ph[i] : 0;
          p = (m_t - LOCK_CYCLES + s) % d;
          e.co[i] = (p < (d + 1) / 2);
          e.ce[i] = (p == d - 1);
        end
      end
      q.push_back(e);
    end
    if (rst) begin
      m_t  = 0;
      m_ok = 1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DEF_DIV;
        m_ph[i]  = 0;
      end
    end else if (m_ok) begin
      if (v && m_t >= LOCK_CYCLES && ch < NUM_CH) begin
        m_div[ch] = dv;
`ifdef CLKDIV_PHASE_EN
        m_ph[ch]  = ph;
`endif
        m_t = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  always @(negedge clkin) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests += 4;
      if (lock !== e.lk) begin
        n_fail++;
        $display("FAIL lock cyc=%0d got=%b exp=%b", e.cyc, lock, e.lk);
      end
      if (cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL cfg_ready cyc=%0d got=%b exp=%b", e.cyc, cfg_ready, e.rdy);
      end
      if (clkout !== e.co) begin
        n_fail++;
        $display("FAIL clkout cyc=%0d got=%b exp=%b", e.cyc, clkout, e.co);
      end
      if (clken !== e.ce) begin
        n_fail++;
        $display("FAIL clken cyc=%0d got=%b exp=%b", e.cyc, clken, e.ce);
      end
    end
  end

  initial begin
    int dv, ph, ch;
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(72);
    step(1'b0, 1'b1, 1, 5, 0);
    idle(80);
    step(1'b0, 1'b1, 2, 0, 0);
    idle(75);
    step(1'b0, 1'b1, 3, 9, 0);
    idle(20);
    step(1'b0, 1'b1, 0, 4, 2);
    idle(75);
    step(1'b0, 1'b1, 0, 4, 7);
    idle(75);
    step(1'b0, 1'b1, 0, 7, 0);
    idle(19);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(72);
    for (int r = 0; r < 40; r++) begin
      idle($urandom_range(0, 90));
      ch = $urandom_range(0, 3);
      dv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      ph = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'b0, 0, 0, 0);
      else step(1'b0, 1'b1, ch, dv, ph);
      step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 9), 0);
    end
    idle(3);
    @(posedge clkin);
    @(posedge clkin);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
